// File: rtl/water_inlet_arbiter.sv
// Round-robin arbiter that shares one water inlet valve between N_REQ washer controllers.
// Each grant is capped at MAX_HOLD unpaused cycles and followed by a GAP_CYCLES valve-switching gap.
module water_inlet_arbiter #(
  parameter int N_REQ      = 4,
  parameter int CNT_W      = 16,
  parameter int MAX_HOLD   = 1000,
  parameter int GAP_CYCLES = 2,
  localparam int ID_W      = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             pause,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id,
  output logic             valve_open,
  output logic [N_REQ-1:0] preempt,
  output logic             busy
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [ID_W-1:0]  RR_INIT   = ID_W'(N_REQ - 1);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] preempt_q, preempt_d;
  logic [ID_W-1:0]  grant_id_q, grant_id_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;

  logic             sel_found;
  logic [ID_W-1:0]  sel_idx;
  logic [ID_W-1:0]  cand;

  // Search starts just past the last owner, so it naturally ends up last in line.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      cand = ID_W'((int'(rr_ptr_q) + off) % N_REQ);
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    preempt_d  = '0;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    case (state_q)
      IDLE: begin
        if (!pause && sel_found) begin
          grant_d    = N_REQ'(1) << sel_idx;
          grant_id_d = sel_idx;
          rr_ptr_d   = sel_idx;
          hold_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (!pause) begin
          // A dropped request wins over the hold limit: no preempt in that case.
          if (!req[grant_id_q]) begin
            grant_d   = '0;
            gap_cnt_d = '0;
            state_d   = GAP;
          end else if (hold_cnt_q == HOLD_LAST) begin
            grant_d   = '0;
            preempt_d = grant_q;
            gap_cnt_d = '0;
            state_d   = GAP;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
      end
      GAP: begin
        if (!pause) begin
          gap_cnt_d = gap_cnt_q + 1'b1;
          if (gap_cnt_q == GAP_LAST) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      preempt_q  <= '0;
      grant_id_q <= '0;
      rr_ptr_q   <= RR_INIT;
      hold_cnt_q <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      preempt_q  <= preempt_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  assign grant      = grant_q;
  assign grant_id   = grant_id_q;
  assign preempt    = preempt_q;
  assign valve_open = (|grant_q) & ~pause;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_water_inlet_arbiter.sv
// Bench for water_inlet_arbiter: fixed vector table, hand-written corner sequences,
// and random traffic checked against an owner/countdown model of the sharing rules.
module tb_water_inlet_arbiter;
  localparam int N  = 4;
  localparam int MH = 4;
  localparam int GC = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  logic         pause;
  logic [N-1:0] grant;
  logic [1:0]   grant_id;
  logic         valve_open;
  logic [N-1:0] preempt;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  water_inlet_arbiter #(
    .N_REQ(N), .CNT_W(16), .MAX_HOLD(MH), .GAP_CYCLES(GC)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .pause(pause),
    .grant(grant), .grant_id(grant_id), .valve_open(valve_open),
    .preempt(preempt), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: current owner (-1 none), unpaused cycles already held,
  // gap cycles still to wait, last owner for round robin, displayed id, preempted owner.
  int m_owner, m_held, m_gap, m_last, m_id, m_pre;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_owner = -1; m_held = 0; m_gap = 0; m_last = N - 1; m_id = 0; m_pre = -1;
  endfunction

  function automatic void model_step(input logic [N-1:0] r, input logic p);
    int c;
    m_pre = -1;
    if (m_owner >= 0) begin
      if (!p) begin
        if (!r[m_owner]) begin
          m_owner = -1; m_gap = GC;
        end else if (m_held + 1 == MH) begin
          m_pre = m_owner; m_owner = -1; m_gap = GC;
        end else begin
          m_held++;
        end
      end
    end else if (m_gap > 0) begin
      if (!p) m_gap--;
    end else if (!p && r != '0) begin
      for (int i = 1; i <= N; i++) begin
        c = (m_last + i) % N;
        if (r[c]) begin
          m_owner = c; m_last = c; m_id = c; m_held = 0;
          break;
        end
      end
    end
  endfunction

  task automatic check_model(input string tag);
    chk({tag, ".grant"},    int'(grant),      (m_owner >= 0) ? (1 << m_owner) : 0);
    chk({tag, ".grant_id"}, int'(grant_id),   m_id);
    chk({tag, ".valve"},    int'(valve_open), (m_owner >= 0 && !pause) ? 1 : 0);
    chk({tag, ".preempt"},  int'(preempt),    (m_pre >= 0) ? (1 << m_pre) : 0);
    chk({tag, ".busy"},     int'(busy),       (m_owner >= 0 || m_gap > 0) ? 1 : 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".grant"},   int'(grant),      0);
    chk({tag, ".id"},      int'(grant_id),   0);
    chk({tag, ".valve"},   int'(valve_open), 0);
    chk({tag, ".preempt"}, int'(preempt),    0);
    chk({tag, ".busy"},    int'(busy),       0);
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
  task automatic step(input logic [N-1:0] r, input logic p, input string tag);
    req = r; pause = p;
    @(posedge clk);
    model_step(r, p);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    req = '0; pause = 1'b0; reset = 1'b0;
    #1;
    check_zero("reset");
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic mid_reset(input string tag);
    #2;
    reset = 1'b0; req = '0; pause = 1'b0;
    #1;
    check_zero(tag);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic         pause;
    logic [N-1:0] grant;
    int           id;
    logic         valve;
    logic [N-1:0] pre;
    logic         busy;
  } vec_t;

  vec_t tbl[13];

  initial begin
    logic [N-1:0] rr;
    tbl[0]  = '{4'b0001, 1'b0, 4'b0001, 0, 1'b1, 4'b0000, 1'b1};
    tbl[1]  = '{4'b0000, 1'b0, 4'b0000, 0, 1'b0, 4'b0000, 1'b1};
    tbl[2]  = '{4'b0000, 1'b0, 4'b0000, 0, 1'b0, 4'b0000, 1'b1};
    tbl[3]  = '{4'b0000, 1'b0, 4'b0000, 0, 1'b0, 4'b0000, 1'b0};
    tbl[4]  = '{4'b1111, 1'b0, 4'b0010, 1, 1'b1, 4'b0000, 1'b1};
    tbl[5]  = '{4'b1111, 1'b0, 4'b0010, 1, 1'b1, 4'b0000, 1'b1};
    tbl[6]  = '{4'b1111, 1'b0, 4'b0010, 1, 1'b1, 4'b0000, 1'b1};
    tbl[7]  = '{4'b1111, 1'b0, 4'b0010, 1, 1'b1, 4'b0000, 1'b1};
    tbl[8]  = '{4'b1111, 1'b0, 4'b0000, 1, 1'b0, 4'b0010, 1'b1};
    tbl[9]  = '{4'b1111, 1'b0, 4'b0000, 1, 1'b0, 4'b0000, 1'b1};
    tbl[10] = '{4'b1111, 1'b0, 4'b0000, 1, 1'b0, 4'b0000, 1'b0};
    tbl[11] = '{4'b1111, 1'b0, 4'b0100, 2, 1'b1, 4'b0000, 1'b1};
    tbl[12] = '{4'b1111, 1'b1, 4'b0100, 2, 1'b0, 4'b0000, 1'b1};

    do_reset();
    for (int v = 0; v < 13; v++) begin
      step(tbl[v].req, tbl[v].pause, $sformatf("vec%0d", v));
      chk($sformatf("tbl%0d.grant", v),   int'(grant),      int'(tbl[v].grant));
      chk($sformatf("tbl%0d.id", v),      int'(grant_id),   tbl[v].id);
      chk($sformatf("tbl%0d.valve", v),   int'(valve_open), int'(tbl[v].valve));
      chk($sformatf("tbl%0d.preempt", v), int'(preempt),    int'(tbl[v].pre));
      chk($sformatf("tbl%0d.busy", v),    int'(busy),       int'(tbl[v].busy));
    end

    // Wrap-around: last owner 1, then 0 and 1 together -> 0, then 1.
    do_reset();
    step(4'b0010, 1'b0, "wrap_a");
    chk("wrap_first_id", int'(grant_id), 1);
    repeat (3) step(4'b0000, 1'b0, "wrap_gap");
    step(4'b0011, 1'b0, "wrap_b");
    chk("wrap_to_zero", int'(grant_id), 0);
    repeat (3) step(4'b0000, 1'b0, "wrap_gap2");
    step(4'b0011, 1'b0, "wrap_c");
    chk("wrap_then_one", int'(grant_id), 1);

    // Pause during grant at hold count 2.
    do_reset();
    step(4'b0100, 1'b0, "pz_grant");
    step(4'b0100, 1'b0, "pz_h1");
    step(4'b0100, 1'b0, "pz_h2");
    for (int i = 0; i < 10; i++) begin
      step(4'b0100, 1'b1, "pz_hold");
      chk("pause_grant_held", int'(grant), 4);
      chk("pause_valve_closed", int'(valve_open), 0);
    end
    step(4'b0100, 1'b0, "pz_r1");
    chk("pause_no_early_preempt", int'(preempt), 0);
    step(4'b0100, 1'b0, "pz_r2");
    chk("pause_preempt", int'(preempt), 4);
    repeat (3) step(4'b0000, 1'b0, "pz_gap");

    // Owner drops request on its last permitted cycle: voluntary release.
    step(4'b0001, 1'b0, "lc_grant");
    repeat (3) step(4'b0001, 1'b0, "lc_hold");
    step(4'b0000, 1'b0, "lc_drop");
    chk("lastcycle_no_preempt", int'(preempt), 0);
    chk("lastcycle_gap_busy", int'(busy), 1);
    repeat (2) step(4'b0000, 1'b0, "lc_gap");

    // Asynchronous reset in GRANT and in GAP.
    step(4'b1000, 1'b0, "rst_grant");
    mid_reset("rst_mid_grant");
    step(4'b0001, 1'b0, "rst_g2");
    step(4'b0000, 1'b0, "rst_gap");
    mid_reset("rst_mid_gap");
    step(4'b1000, 1'b0, "rst_after");
    chk("after_reset_id3", int'(grant_id), 3);
    chk("after_reset_grant", int'(grant), 8);

    // Random traffic against the model.
    do_reset();
    rr = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 7) == 0) rr[b] = ~rr[b];
      step(rr, ($urandom_range(0, 9) == 0), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
